aesl_deadlock_report_arbiter: RTL and testbench

//   Collects per-instance block flags and axis info vectors from NUM_MON deadlock

---
 rtl/aesl_deadlock_report_arbiter.sv | 136 +++++++++++++
 tb/tb_aesl_deadlock_report_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aesl_deadlock_report_arbiter.sv
// Debounces per-monitor deadlock block flags and round-robin arbitrates confirmed
// deadlocks into a single valid/ready report stream with info and cycle stamp.
module aesl_deadlock_report_arbiter #(
  parameter int unsigned NUM_MON = 4,
  parameter int unsigned INFO_W  = 4,
  parameter int unsigned THRESH  = 16,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_MON-1:0]        mon_block,
  input  logic [NUM_MON*INFO_W-1:0] mon_info,
  output logic [NUM_MON-1:0]        confirmed,
  output logic                      deadlock,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [IDX_W-1:0]          rpt_idx,
  output logic [INFO_W-1:0]         rpt_info,
  output logic [31:0]               rpt_cycle,
  output logic                      busy
);

  localparam int unsigned CntW = $clog2(THRESH + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t Thresh   = cnt_t'(THRESH);
  localparam cnt_t ThreshM1 = cnt_t'(THRESH - 1);

  typedef enum logic {StIdle, StReport} state_e;

  state_e             state_q, state_d;
  logic [31:0]        cyc_q;
  cnt_t               cnt_q [NUM_MON];
  cnt_t               cnt_d [NUM_MON];
  logic [NUM_MON-1:0] confirmed_q, confirmed_d;
  logic [NUM_MON-1:0] reported_q, reported_d;
  logic [NUM_MON-1:0] eligible;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   rpt_idx_q, rpt_idx_d;
  logic [INFO_W-1:0]  rpt_info_q, rpt_info_d;
  logic [31:0]        rpt_cycle_q, rpt_cycle_d;
  logic [IDX_W-1:0]   grant_idx, cand;
  logic               grant_found;
  logic               handshake;
  logic [INFO_W-1:0]  info_arr [NUM_MON];

  for (genvar g = 0; g < NUM_MON; g++) begin : g_info
    assign info_arr[g] = mon_info[g*INFO_W +: INFO_W];
  end

  assign handshake = (state_q == StReport) && rpt_ready;
  assign eligible  = confirmed_q & ~reported_q;

  // Debounce and reported-mask update; a low block flag clears everything for that monitor.
  always_comb begin
    for (int i = 0; i < NUM_MON; i++) begin
      cnt_d[i]       = '0;
      confirmed_d[i] = 1'b0;
      reported_d[i]  = 1'b0;
      if (mon_block[i]) begin
        cnt_d[i]       = (cnt_q[i] == Thresh) ? cnt_q[i] : cnt_q[i] + cnt_t'(1);
        confirmed_d[i] = (cnt_q[i] >= ThreshM1);
        reported_d[i]  = reported_q[i] | (handshake && (rpt_idx_q == IDX_W'(i)));
      end
    end
  end

  // Round-robin scan starting just after the last granted index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = last_grant_q;
    for (int k = 1; k <= int'(NUM_MON); k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % int'(NUM_MON));
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rpt_idx_d    = rpt_idx_q;
    rpt_info_d   = rpt_info_q;
    rpt_cycle_d  = rpt_cycle_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          state_d      = StReport;
          last_grant_d = grant_idx;
          rpt_idx_d    = grant_idx;
          rpt_info_d   = info_arr[grant_idx];
          rpt_cycle_d  = cyc_q;
        end
      end
      StReport: begin
        if (rpt_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cyc_q        <= '0;
      confirmed_q  <= '0;
      reported_q   <= '0;
      last_grant_q <= IDX_W'(NUM_MON - 1);
      rpt_idx_q    <= '0;
      rpt_info_q   <= '0;
      rpt_cycle_q  <= '0;
      for (int i = 0; i < NUM_MON; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_q + 32'd1;
      confirmed_q  <= confirmed_d;
      reported_q   <= reported_d;
      last_grant_q <= last_grant_d;
      rpt_idx_q    <= rpt_idx_d;
      rpt_info_q   <= rpt_info_d;
      rpt_cycle_q  <= rpt_cycle_d;
      for (int i = 0; i < NUM_MON; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign confirmed = confirmed_q;
  assign deadlock  = |confirmed_q;
  assign rpt_valid = (state_q == StReport);
  assign busy      = (state_q != StIdle);
  assign rpt_idx   = rpt_idx_q;
  assign rpt_info  = rpt_info_q;
  assign rpt_cycle = rpt_cycle_q;

endmodule

// File: tb/tb_aesl_deadlock_report_arbiter.sv
// Randomised scoreboard bench for the deadlock report arbiter against a
// behavioural model of run lengths, reported flags and round-robin grants.
module tb_aesl_deadlock_report_arbiter;
  localparam int NUM_MON = 4;
  localparam int INFO_W  = 4;
  localparam int THRESH  = 4;
  localparam int IDX_W   = 2;

  logic                      clock = 1'b0;
  logic                      reset = 1'b0;
  logic [NUM_MON-1:0]        mon_block = '0;
  logic [NUM_MON*INFO_W-1:0] mon_info = '0;
  logic [NUM_MON-1:0]        confirmed;
  logic                      deadlock;
  logic                      rpt_valid;
  logic                      rpt_ready = 1'b0;
  logic [IDX_W-1:0]          rpt_idx;
  logic [INFO_W-1:0]         rpt_info;
  logic [31:0]               rpt_cycle;
  logic                      busy;

  aesl_deadlock_report_arbiter #(
    .NUM_MON(NUM_MON), .INFO_W(INFO_W), .THRESH(THRESH), .IDX_W(IDX_W)
  ) dut (
    .clock(clock), .reset(reset), .mon_block(mon_block), .mon_info(mon_info),
    .confirmed(confirmed), .deadlock(deadlock), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .rpt_idx(rpt_idx), .rpt_info(rpt_info),
    .rpt_cycle(rpt_cycle), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int                idx;
    logic [INFO_W-1:0] info;
    logic [31:0]       cyc;
  } rpt_t;

  rpt_t        exp_q[$];
  int          m_run [NUM_MON];
  bit          m_rep [NUM_MON];
  bit          m_valid;
  int          m_idx;
  int          m_last;
  logic [31:0] m_cyc;
  int n_checks = 0, n_fail = 0, n_grants = 0, n_seen = 0, n_flushed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_MON-1:0] m_conf_vec();
    logic [NUM_MON-1:0] v;
    for (int i = 0; i < NUM_MON; i++) v[i] = (m_run[i] >= THRESH);
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_MON; i++) begin
      m_run[i] = 0;
      m_rep[i] = 0;
    end
    m_valid = 0;
    m_idx   = 0;
    m_last  = NUM_MON - 1;
    m_cyc   = 0;
    n_flushed += exp_q.size();
    exp_q.delete();
  endfunction

  // One clock of the reference behaviour, using the inputs present before the edge.
  function automatic void model_step();
    bit hs = m_valid && rpt_ready;
    int g = -1;
    if (!m_valid)
      for (int k = 1; k <= NUM_MON; k++) begin
        int j = (m_last + k) % NUM_MON;
        if (g < 0 && m_run[j] >= THRESH && !m_rep[j]) g = j;
      end
    for (int i = 0; i < NUM_MON; i++) begin
      if (!mon_block[i]) begin
        m_run[i] = 0;
        m_rep[i] = 0;
      end else begin
        if (m_run[i] < THRESH) m_run[i]++;
        if (hs && m_idx == i) m_rep[i] = 1;
      end
    end
    if (hs) m_valid = 0;
    if (g >= 0) begin
      m_valid = 1;
      m_idx   = g;
      m_last  = g;
      exp_q.push_back('{idx: g, info: mon_info[g*INFO_W +: INFO_W], cyc: m_cyc});
      n_grants++;
    end
    m_cyc = m_cyc + 32'd1;
  endfunction

  task automatic tick();
    @(posedge clock);
    if (!reset) model_step();
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_valid", rpt_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_confirmed", confirmed, 0);
    chk("reset_deadlock", deadlock, 0);
    chk("reset_idx", rpt_idx, 0);
    chk("reset_info", rpt_info, 0);
    chk("reset_cycle", rpt_cycle, 0);
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic set_info(input int i, input logic [INFO_W-1:0] v);
    mon_info[i*INFO_W +: INFO_W] = v;
  endtask

  // Monitor: compares the DUT against the model and pops reports on handshake.
  initial begin
    forever begin
      @(negedge clock);
      chk("rpt_valid", rpt_valid, m_valid);
      chk("busy", busy, m_valid);
      chk("confirmed", confirmed, m_conf_vec());
      chk("deadlock", deadlock, |m_conf_vec());
      if (rpt_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_report: got idx %0d expected no report", rpt_idx);
        end else begin
          chk("rpt_idx", rpt_idx, exp_q[0].idx);
          chk("rpt_info", rpt_info, exp_q[0].info);
          chk("rpt_cycle", rpt_cycle, exp_q[0].cyc);
          if (rpt_ready) begin
            void'(exp_q.pop_front());
            n_seen++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    do_reset(2);

    // Short block episode never confirms.
    rpt_ready = 1'b1;
    mon_block = 4'b0010;
    repeat (3) tick();
    mon_block = 4'b0000;
    repeat (4) tick();

    // Held block yields exactly one report.
    set_info(2, 4'hD);
    mon_block = 4'b0100;
    repeat (14) tick();
    mon_block = 4'b0000;
    repeat (2) tick();

    // Simultaneous confirm after reset: idx 0 then idx 3.
    do_reset(1);
    mon_block = 4'b1001;
    repeat (10) tick();
    mon_block = 4'b0000;
    tick();

    // Consumer stalls while info churns.
    rpt_ready = 1'b0;
    mon_block = 4'b0010;
    repeat (16) begin
      mon_info = NUM_MON*INFO_W'($urandom);
      tick();
    end
    rpt_ready = 1'b1;
    repeat (3) tick();

    // Reset in the middle of a report with the monitor still blocked.
    rpt_ready = 1'b0;
    mon_block = 4'b0100;
    for (int n = 0; n < 20 && !m_valid; n++) tick();
    chk("mid_report_valid", rpt_valid, 1);
    do_reset(2);
    rpt_ready = 1'b1;
    repeat (10) tick();

    // Re-raise after drop: same index reported again with a later stamp.
    mon_block = 4'b0000;
    tick();
    mon_block = 4'b0100;
    repeat (6) tick();

    // Random phase.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_MON; i++)
        if ($urandom_range(0, 11) == 0) mon_block[i] = ~mon_block[i];
      if ($urandom_range(0, 3) == 0) mon_info = NUM_MON*INFO_W'($urandom);
      rpt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) do_reset(1);
      else tick();
    end

    mon_block = '0;
    rpt_ready = 1'b1;
    repeat (6) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("reports_accounted", n_seen + n_flushed, n_grants);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
